wm8731_ctrl_responder: RTL and testbench

Behavioural and synthesizable model of the WM8731 2-wire control port. It is the target end of the codec's I2C configuration link. It decodes 3-byte write transactions of the form {dev_addr+W, reg_addr[6:0]+data[8], data[7:0]}, ACKs each byte, and commits the 9-bit data into a 16-entry register file. Used as the codec-side bus-functional responder in system simulation, and as an FPGA loopback target for the I2C controller.

---
 rtl/wm8731_ctrl_responder.sv | 203 ++++++++++++++++++++
 tb/tb_wm8731_ctrl_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module  : wm8731_ctrl_responder
// Brief   : WM8731 2-wire control-port target; ACKs 3-byte writes and commits
//           9-bit data into a 16-entry register file.
// Revision: 1.0 - initial release
// ============================================================================
module wm8731_ctrl_responder #(
  parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  input  logic [3:0] reg_rd_addr,
  output logic [8:0] reg_rd_data,
  output logic       reg_wr_tick,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  output logic       busy,
  output logic       nack_tick
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACK_A  = 3'd2,
    S_BYTE1  = 3'd3,
    S_ACK_1  = 3'd4,
    S_BYTE2  = 3'd5,
    S_ACK_2  = 3'd6,
    S_IGNORE = 3'd7
  } state_t;

  localparam logic [3:0] c_BIT_LAST = 4'd8;
  localparam logic [3:0] c_BIT_ACK  = 4'd9;
  localparam logic [6:0] c_ADDR_RST = 7'd15;
  localparam logic [6:0] c_ADDR_MAX = 7'd9;

  function automatic logic [8:0] f_default(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: f_default = 9'h097;
      4'd2, 4'd3: f_default = 9'h079;
      4'd4:       f_default = 9'h00A;
      4'd5:       f_default = 9'h008;
      4'd6:       f_default = 9'h09F;
      4'd7:       f_default = 9'h00A;
      default:    f_default = 9'h000;
    endcase
  endfunction

  state_t     state_q;
  logic [1:0] sclk_sync_q;
  logic [1:0] sdat_sync_q;
  logic       sclk_prev_q;
  logic       sdat_prev_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [6:0] addr7_q;
  logic       d8_q;
  logic [7:0] d7_0_q;
  logic       sdat_oe_q;
  logic       busy_q;
  logic       wr_tick_q;
  logic       nack_tick_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q;
  logic [8:0] file_q [16];

  logic w_sclk;
  logic w_sdat;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_start;
  logic w_stop;
  logic w_addr_match;

  assign w_sclk       = sclk_sync_q[1];
  assign w_sdat       = sdat_sync_q[1];
  assign w_sclk_rise  = w_sclk & ~sclk_prev_q;
  assign w_sclk_fall  = ~w_sclk & sclk_prev_q;
  assign w_start      = w_sclk & sclk_prev_q & sdat_prev_q & ~w_sdat;
  assign w_stop       = w_sclk & sclk_prev_q & ~sdat_prev_q & w_sdat;
  assign w_addr_match = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];

  assign i2c_sdat    = sdat_oe_q ? 1'b0 : 1'bz;
  assign reg_rd_data = file_q[reg_rd_addr];
  assign reg_wr_tick = wr_tick_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign nack_tick   = nack_tick_q;

  // Bit counter runs 1..8 for data and 9 for the acknowledge clock in every
  // active state; it rolls back to 0 on the falling edge that ends clock 9.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= 2'b11;
      sdat_sync_q <= 2'b11;
      sclk_prev_q <= 1'b1;
      sdat_prev_q <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      addr7_q     <= 7'd0;
      d8_q        <= 1'b0;
      d7_0_q      <= 8'd0;
      sdat_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_tick_q   <= 1'b0;
      nack_tick_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 9'd0;
      for (int i = 0; i < 16; i++) file_q[i] <= f_default(4'(i));
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], i2c_sclk};
      sdat_sync_q <= {sdat_sync_q[0], i2c_sdat};
      sclk_prev_q <= w_sclk;
      sdat_prev_q <= w_sdat;
      wr_tick_q   <= 1'b0;
      nack_tick_q <= 1'b0;

      if (w_start) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= 4'd0;
        busy_q    <= 1'b1;
        sdat_oe_q <= 1'b0;
      end else if (w_stop) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= 4'd0;
        busy_q    <= 1'b0;
        sdat_oe_q <= 1'b0;
      end else if (state_q != S_IDLE) begin
        if (w_sclk_rise) begin
          shift_q <= {shift_q[6:0], w_sdat};
          if (bit_cnt_q != c_BIT_ACK) bit_cnt_q <= bit_cnt_q + 4'd1;
        end else if (w_sclk_fall) begin
          if (bit_cnt_q == c_BIT_ACK) bit_cnt_q <= 4'd0;
          case (state_q)
            S_ADDR: begin
              if (bit_cnt_q == c_BIT_LAST) begin
                if (w_addr_match) begin
                  sdat_oe_q <= 1'b1;
                  state_q   <= S_ACK_A;
                end else begin
                  nack_tick_q <= 1'b1;
                  state_q     <= S_IGNORE;
                end
              end
            end
            S_BYTE1: begin
              if (bit_cnt_q == c_BIT_LAST) begin
                addr7_q   <= shift_q[7:1];
                d8_q      <= shift_q[0];
                sdat_oe_q <= 1'b1;
                state_q   <= S_ACK_1;
              end
            end
            S_BYTE2: begin
              if (bit_cnt_q == c_BIT_LAST) begin
                d7_0_q    <= shift_q;
                sdat_oe_q <= 1'b1;
                state_q   <= S_ACK_2;
              end
            end
            S_ACK_A: begin
              if (bit_cnt_q == c_BIT_ACK) begin
                sdat_oe_q <= 1'b0;
                state_q   <= S_BYTE1;
              end
            end
            S_ACK_1: begin
              if (bit_cnt_q == c_BIT_ACK) begin
                sdat_oe_q <= 1'b0;
                state_q   <= S_BYTE2;
              end
            end
            S_ACK_2: begin
              if (bit_cnt_q == c_BIT_ACK) begin
                sdat_oe_q <= 1'b0;
                wr_tick_q <= 1'b1;
                wr_addr_q <= addr7_q;
                wr_data_q <= {d8_q, d7_0_q};
                if (addr7_q <= c_ADDR_MAX) begin
                  file_q[addr7_q[3:0]] <= {d8_q, d7_0_q};
                end else if (addr7_q == c_ADDR_RST) begin
                  for (int i = 0; i < 16; i++) file_q[i] <= f_default(4'(i));
                end
                state_q <= S_IGNORE;
              end
            end
            S_IGNORE: begin
              if (bit_cnt_q == c_BIT_LAST) nack_tick_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wm8731_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_wm8731_ctrl_responder
// Brief   : Bit-banged I2C initiator with table vectors, random transactions
//           against a transaction-level register model, and corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wm8731_ctrl_responder;

  localparam int c_QTR = 10;
  localparam logic [8:0] C_DEF [16] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000,
                                        9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
                                        9'h000};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data;
  logic       wr_tick;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       nack_tick;
  wire        i2c_sdat;

  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  always #5 clk = ~clk;

  wm8731_ctrl_responder dut (
    .clk         (clk),
    .reset       (reset),
    .i2c_sclk    (scl),
    .i2c_sdat    (i2c_sdat),
    .reg_rd_addr (rd_addr),
    .reg_rd_data (rd_data),
    .reg_wr_tick (wr_tick),
    .reg_wr_addr (wr_addr),
    .reg_wr_data (wr_data),
    .busy        (busy),
    .nack_tick   (nack_tick)
  );

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int nack_cnt = 0;
  logic [8:0] model_q [16];

  always @(negedge clk) begin
    if (wr_tick)   tick_cnt++;
    if (nack_tick) nack_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b0; wait_clks(c_QTR);
    scl = 1'b1;     wait_clks(c_QTR);
    sda_low = 1'b1; wait_clks(c_QTR);
    scl = 1'b0;     wait_clks(c_QTR);
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; wait_clks(c_QTR);
    scl = 1'b1;     wait_clks(c_QTR);
    sda_low = 1'b0; wait_clks(2 * c_QTR);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_low = ~b[i]; wait_clks(c_QTR);
      scl = 1'b1;      wait_clks(2 * c_QTR);
      scl = 1'b0;      wait_clks(c_QTR);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    sda_low = 1'b0; wait_clks(c_QTR);
    scl = 1'b1;     wait_clks(c_QTR);
    ack = (i2c_sdat === 1'b0);
    wait_clks(c_QTR);
    scl = 1'b0;     wait_clks(c_QTR - 2);
    check("sda_released_after_ack", 32'(i2c_sdat), 32'd1);
    wait_clks(2);
  endtask

  task automatic check_file(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), 32'(rd_data), 32'(model_q[i]));
    end
  endtask

  // Transaction-level model: the first byte must be the write address; then
  // at most two more bytes are acknowledged and a third byte commits.
  task automatic model_txn(input logic [31:0] bytes, input int n,
                           output logic [3:0] e_ack, output int e_ticks,
                           output int e_nacks, output logic [6:0] e_addr,
                           output logic [8:0] e_data);
    bit ok;
    e_ack = 4'd0; e_ticks = 0; e_nacks = 0; e_addr = 7'd0; e_data = 9'd0;
    ok = (bytes[7:0] == 8'h34);
    for (int i = 0; i < n; i++) begin
      if (ok && i < 3) e_ack[i] = 1'b1;
      else             e_nacks++;
    end
    if (ok && n >= 3) begin
      e_ticks = 1;
      e_addr  = bytes[15:9];
      e_data  = {bytes[8], bytes[23:16]};
      if (int'(e_addr) <= 9)       model_q[e_addr[3:0]] = e_data;
      else if (int'(e_addr) == 15) for (int i = 0; i < 16; i++) model_q[i] = C_DEF[i];
    end
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] bytes, input int n,
                               input logic [3:0] e_ack, input int e_ticks, input int e_nacks,
                               input logic [6:0] e_addr, input logic [8:0] e_data);
    int   t0, n0;
    logic a;
    t0 = tick_cnt;
    n0 = nack_cnt;
    bus_start();
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(bytes[8*i +: 8], a);
      check($sformatf("%s_ack%0d", tag, i), 32'(a), 32'(e_ack[i]));
    end
    bus_stop();
    check({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
    check({tag, "_wr_ticks"}, 32'(tick_cnt - t0), 32'(e_ticks));
    check({tag, "_nack_ticks"}, 32'(nack_cnt - n0), 32'(e_nacks));
    if (e_ticks > 0) begin
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'(e_addr));
      check({tag, "_wr_data"}, 32'(wr_data), 32'(e_data));
    end
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [3:0]  ack;
    int          ticks;
    int          nacks;
    logic [6:0]  addr;
    logic [8:0]  data;
    logic [3:0]  rd_idx;
    logic [8:0]  rd_val;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [3:0] m_ack;
    int         m_ticks, m_nacks, t0;
    logic [6:0] m_addr;
    logic [8:0] m_data;
    logic       a;

    vecs[0] = '{32'h00_12_08_34, 3, 4'b0111, 1, 0, 7'd4,  9'h012, 4'd4,  9'h012};
    vecs[1] = '{32'h00_00_00_36, 1, 4'b0000, 0, 1, 7'd0,  9'h000, 4'd4,  9'h012};
    vecs[2] = '{32'h00_00_08_35, 3, 4'b0000, 0, 3, 7'd0,  9'h000, 4'd4,  9'h012};
    vecs[3] = '{32'h00_FF_05_34, 3, 4'b0111, 1, 0, 7'd2,  9'h1FF, 4'd2,  9'h1FF};
    vecs[4] = '{32'h00_00_1E_34, 3, 4'b0111, 1, 0, 7'd15, 9'h000, 4'd2,  9'h079};
    vecs[5] = '{32'hAA_05_0C_34, 4, 4'b0111, 1, 1, 7'd6,  9'h005, 4'd6,  9'h005};
    vecs[6] = '{32'h00_55_18_34, 3, 4'b0111, 1, 0, 7'd12, 9'h055, 4'd12, 9'h000};
    vecs[7] = '{32'h00_34_13_34, 3, 4'b0111, 1, 0, 7'd9,  9'h134, 4'd9,  9'h134};

    for (int i = 0; i < 16; i++) model_q[i] = C_DEF[i];

    // Reset state
    wait_clks(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sdat", 32'(i2c_sdat), 32'd1);
    check("rst_wr_tick", 32'(wr_tick), 32'd0);
    check("rst_nack_tick", 32'(nack_tick), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    reset = 1'b1;
    wait_clks(5);
    check_file("rst");

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      model_txn(vecs[v].bytes, vecs[v].n, m_ack, m_ticks, m_nacks, m_addr, m_data);
      run_and_check($sformatf("vec%0d", v), vecs[v].bytes, vecs[v].n, vecs[v].ack,
                    vecs[v].ticks, vecs[v].nacks, vecs[v].addr, vecs[v].data);
      rd_addr = vecs[v].rd_idx;
      #1;
      check($sformatf("vec%0d_readback", v), 32'(rd_data), 32'(vecs[v].rd_val));
      wait_clks(1);
    end
    check_file("table");

    // Randomised transactions against the model
    for (int r = 0; r < 20; r++) begin
      logic [7:0]  b0, b1, b2, b3;
      int          n;
      n  = int'($urandom_range(1, 4));
      b0 = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
      b1 = {3'd0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 4) == 0) b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      b3 = 8'($urandom_range(0, 255));
      model_txn({b3, b2, b1, b0}, n, m_ack, m_ticks, m_nacks, m_addr, m_data);
      run_and_check($sformatf("rnd%0d", r), {b3, b2, b1, b0}, n, m_ack, m_ticks,
                    m_nacks, m_addr, m_data);
      check_file($sformatf("rnd%0d", r));
    end

    // Abort with STOP after the second byte's ACK: nothing commits
    t0 = tick_cnt;
    bus_start();
    write_byte(8'h34, a); check("abort_ack0", 32'(a), 32'd1);
    write_byte(8'h08, a); check("abort_ack1", 32'(a), 32'd1);
    bus_stop();
    check("abort_no_tick", 32'(tick_cnt - t0), 32'd0);
    check_file("abort");

    // Repeated START mid-write, then a full write of R5
    bus_start();
    write_byte(8'h34, a);
    write_byte(8'h08, a);
    bus_start();
    write_byte(8'h34, a); check("rs_ack0", 32'(a), 32'd1);
    write_byte(8'h0A, a); check("rs_ack1", 32'(a), 32'd1);
    write_byte(8'h01, a); check("rs_ack2", 32'(a), 32'd1);
    bus_stop();
    model_q[5] = 9'h001;
    check("rs_one_tick", 32'(tick_cnt - t0), 32'd1);
    check("rs_wr_addr", 32'(wr_addr), 32'd5);
    check("rs_wr_data", 32'(wr_data), 32'h001);
    rd_addr = 4'd5;
    #1;
    check("rs_R5", 32'(rd_data), 32'h001);
    wait_clks(1);
    check_file("rs");

    // Asynchronous reset while the responder holds ACK of the second byte
    bus_start();
    write_byte(8'h34, a);
    send_bits(8'h08);
    sda_low = 1'b0; wait_clks(c_QTR);
    scl = 1'b1;     wait_clks(c_QTR);
    check("arst_ack_held", 32'(i2c_sdat), 32'd0);
    reset = 1'b0;
    #1;
    check("arst_sdat_released", 32'(i2c_sdat), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) model_q[i] = C_DEF[i];
    wait_clks(2);
    check_file("arst");
    reset = 1'b1;
    wait_clks(2 * c_QTR);

    // Responder is usable again after reset
    model_txn(32'h00_12_08_34, 3, m_ack, m_ticks, m_nacks, m_addr, m_data);
    run_and_check("post_rst", 32'h00_12_08_34, 3, 4'b0111, 1, 0, 7'd4, 9'h012);
    check_file("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
